// File: rtl/lm_sm_sequencer.sv
// Purpose: LM/SM sequencer. It walks an 8-bit register mask from R0 to R7 and issues one transfer per cycle.
// Latency: accept in cycle 0, transfers in cycles 1..N, done in cycle N+1, IDLE again in cycle N+2.
// Backpressure: none. Memory and the register file complete every transfer in one cycle, and busy stalls the core.
//
// Ports:
//   clk, rst                          clock and asynchronous active-high reset
//   start, is_lm, base_addr, reg_mask decoder request and operands, latched on accept
//   reg_read_addr / reg_read_data     register-file read port (SM source)
//   reg_write_en/_dest/_data          register-file write port (LM)
//   mem_addr, mem_rd_data             data-memory address and combinational read data
//   mem_wr_en, mem_wr_data            data-memory synchronous write port (SM)
//   busy, done                        PC hold and single-cycle completion pulse
module lm_sm_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_lm,
  input  logic [15:0]           base_addr,
  input  logic [7:0]            reg_mask,
  output logic [2:0]            reg_read_addr,
  input  logic [DATA_WIDTH-1:0] reg_read_data,
  output logic                  reg_write_en,
  output logic [2:0]            reg_write_dest,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic [15:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [15:0] STEP = 16'(ADDR_STEP);

  logic [1:0]  state;
  logic [7:0]  rem_mask;
  logic [15:0] cur_addr;
  logic        op_lm;

  logic [2:0]  idx;
  logic [7:0]  rem_next;
  logic        in_xfer;

  // Lowest set bit wins. The loop scans downwards, so the last hit (the lowest index) is kept.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_mask[i]) idx = 3'(i);
    end
  end

  assign rem_next = rem_mask & ~(8'b1 << idx);
  assign in_xfer  = (state == ST_XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rem_mask <= 8'd0;
      cur_addr <= 16'd0;
      op_lm    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem_mask <= reg_mask;
            cur_addr <= base_addr;
            op_lm    <= is_lm;
            state    <= (reg_mask != 8'd0) ? ST_XFER : ST_DONE;
          end
        end
        ST_XFER: begin
          rem_mask <= rem_next;
          // Wraps modulo 2^16 without raising an error.
          cur_addr <= cur_addr + STEP;
          if (rem_next == 8'd0) state <= ST_DONE;
        end
        // DONE ignores start: the same LM/SM instruction is still at the PC in this cycle.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr       = cur_addr;
  assign reg_write_en   = in_xfer & op_lm;
  assign reg_write_dest = (in_xfer & op_lm) ? idx : 3'd0;
  assign reg_write_data = mem_rd_data;
  assign mem_wr_en      = in_xfer & ~op_lm;
  assign reg_read_addr  = (in_xfer & ~op_lm) ? idx : 3'd0;
  assign mem_wr_data    = reg_read_data;

  // Raising busy in the accept cycle holds the PC before the FSM has left IDLE.
  assign busy = ((state == ST_IDLE) & start) | in_xfer;
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Purpose: self-checking bench for lm_sm_sequencer, with register-file and memory models and a write scoreboard.
// Latency: expected writes carry the cycle in which they must appear, relative to the accept cycle.
// Backpressure: none. The models complete every access in the same cycle.
module tb_lm_sm_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_lm;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic [2:0]  reg_read_addr;
  logic [15:0] reg_read_data;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic        busy;
  logic        done;

  logic [15:0] mem  [0:65535];
  logic [15:0] regs [0:7];

  typedef struct {
    bit          lm;
    logic [15:0] addr;
    logic [2:0]  r;
    logic [15:0] data;
    int          cyc;
  } xfer_t;

  xfer_t sb[$];
  int    checks;
  int    errors;
  int    cyc;

  lm_sm_sequencer #(.DATA_WIDTH(16), .ADDR_STEP(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .is_lm          (is_lm),
    .base_addr      (base_addr),
    .reg_mask       (reg_mask),
    .reg_read_addr  (reg_read_addr),
    .reg_read_data  (reg_read_data),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_data    (mem_wr_data),
    .busy           (busy),
    .done           (done)
  );

  assign reg_read_data = regs[reg_read_addr];
  assign mem_rd_data   = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one expected transfer per set mask bit, in R0..R7 order, at consecutive addresses.
  task automatic push_expect(input bit lm, input logic [15:0] base, input logic [7:0] mask, input int c0);
    xfer_t e;
    int    j;
    j = 0;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) begin
        e.lm   = lm;
        e.addr = base + 16'(j);
        e.r    = 3'(k);
        e.data = lm ? mem[base + 16'(j)] : regs[k];
        e.cyc  = c0 + 1 + j;
        sb.push_back(e);
        j++;
      end
    end
  endtask

  // Sample at the negedge: match any write against the scoreboard, then apply it to the models.
  task automatic commit_writes();
    xfer_t       e;
    logic [2:0]  obs_r;
    logic [15:0] obs_d;
    if (reg_write_en || mem_wr_en) begin
      checks++;
      obs_r = reg_write_en ? reg_write_dest : reg_read_addr;
      obs_d = reg_write_en ? reg_write_data : mem_wr_data;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d lm=%b addr=%h r=%0d data=%h", cyc, reg_write_en, mem_addr, obs_r, obs_d);
      end else begin
        e = sb.pop_front();
        if ((reg_write_en && mem_wr_en) || (reg_write_en !== e.lm) || (cyc != e.cyc) ||
            (mem_addr !== e.addr) || (obs_r !== e.r) || (obs_d !== e.data)) begin
          errors++;
          $display("FAIL xfer got cyc=%0d lm=%b wen=%b addr=%h r=%0d data=%h exp cyc=%0d lm=%b addr=%h r=%0d data=%h",
                   cyc, reg_write_en, mem_wr_en, mem_addr, obs_r, obs_d, e.cyc, e.lm, e.addr, e.r, e.data);
        end
      end
      if (reg_write_en) regs[reg_write_dest] = reg_write_data;
      if (mem_wr_en) mem[mem_addr] = mem_wr_data;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete operation, checking busy/done every cycle. Operands may be scrambled after accept.
  task automatic run_op(input bit lm, input logic [15:0] base, input logic [7:0] mask, input bit scramble);
    int n;
    n = $countones(mask);
    is_lm = lm; base_addr = base; reg_mask = mask; start = 1'b1;
    push_expect(lm, base, mask, cyc);
    for (int i = 0; i <= n + 2; i++) begin
      @(negedge clk);
      checks += 2;
      if (busy !== 1'(i <= n)) begin
        errors++; $display("FAIL busy i=%0d got=%b exp=%b", i, busy, 1'(i <= n));
      end
      if (done !== 1'(i == n + 1)) begin
        errors++; $display("FAIL done i=%0d got=%b exp=%b", i, done, 1'(i == n + 1));
      end
      commit_writes();
      next_cycle();
      start = 1'b0;
      if (scramble) begin
        is_lm = ~lm; base_addr = 16'hDEAD; reg_mask = ~mask;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL missing_writes got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_lm = 1'b0; base_addr = 16'h1111; reg_mask = 8'hFF;
    #1;
    checks += 6;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_start got=%b exp=1", busy); end
    if (reg_write_en !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL rst_wen got=%b%b exp=00", reg_write_en, mem_wr_en);
    end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%h exp=0000", mem_addr); end
    if (reg_read_addr !== 3'd0 || reg_write_dest !== 3'd0) begin
      errors++; $display("FAIL rst_ridx got=%0d/%0d exp=0/0", reg_read_addr, reg_write_dest);
    end
    start = 1'b0;
    #1;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_lm_basic();
    mem[16'h0040] = 16'hAAAA; mem[16'h0041] = 16'hBBBB; mem[16'h0042] = 16'hCCCC;
    run_op(1'b1, 16'h0040, 8'h16, 1'b1);
    checks += 3;
    if (regs[1] !== 16'hAAAA) begin errors++; $display("FAIL lm_r1 got=%h exp=AAAA", regs[1]); end
    if (regs[2] !== 16'hBBBB) begin errors++; $display("FAIL lm_r2 got=%h exp=BBBB", regs[2]); end
    if (regs[4] !== 16'hCCCC) begin errors++; $display("FAIL lm_r4 got=%h exp=CCCC", regs[4]); end
  endtask

  task automatic test_sm_basic();
    regs[0] = 16'h1234; regs[7] = 16'h5678;
    run_op(1'b0, 16'h0100, 8'h81, 1'b1);
    checks += 2;
    if (mem[16'h0100] !== 16'h1234) begin errors++; $display("FAIL sm_m100 got=%h exp=1234", mem[16'h0100]); end
    if (mem[16'h0101] !== 16'h5678) begin errors++; $display("FAIL sm_m101 got=%h exp=5678", mem[16'h0101]); end
  endtask

  task automatic test_empty_mask();
    run_op(1'b1, 16'h0400, 8'h00, 1'b0);
    run_op(1'b0, 16'h0400, 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    regs[0] = 16'h0A0A; regs[1] = 16'h1B1B;
    run_op(1'b0, 16'hFFFF, 8'h03, 1'b0);
    checks += 2;
    if (mem[16'hFFFF] !== 16'h0A0A) begin errors++; $display("FAIL wrap_ffff got=%h exp=0A0A", mem[16'hFFFF]); end
    if (mem[16'h0000] !== 16'h1B1B) begin errors++; $display("FAIL wrap_0000 got=%h exp=1B1B", mem[16'h0000]); end
  endtask

  task automatic test_reset_mid_xfer();
    logic [15:0] old_r2;
    for (int k = 0; k < 8; k++) mem[16'h0300 + 16'(k)] = 16'hC000 + 16'(k);
    old_r2 = regs[2];
    is_lm = 1'b1; base_addr = 16'h0300; reg_mask = 8'hFF; start = 1'b1;
    push_expect(1'b1, 16'h0300, 8'hFF, cyc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy i=%0d got=%b exp=1", i, busy); end
      commit_writes();
      next_cycle();
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 7;
    if (reg_write_en !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL rmid_wen got=%b%b exp=00", reg_write_en, mem_wr_en);
    end
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rmid_busy_done got=%b%b exp=00", busy, done);
    end
    if (mem_addr !== 16'h0000 || reg_write_dest !== 3'd0) begin
      errors++; $display("FAIL rmid_addr got=%h/%0d exp=0000/0", mem_addr, reg_write_dest);
    end
    if (regs[0] !== 16'hC000) begin errors++; $display("FAIL rmid_r0 got=%h exp=C000", regs[0]); end
    if (regs[1] !== 16'hC001) begin errors++; $display("FAIL rmid_r1 got=%h exp=C001", regs[1]); end
    if (regs[2] !== old_r2) begin errors++; $display("FAIL rmid_r2 got=%h exp=%h", regs[2], old_r2); end
    if (sb.size() != 6) begin errors++; $display("FAIL rmid_pending got=%0d exp=6", sb.size()); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || reg_write_en !== 1'b0) begin
        errors++; $display("FAIL rmid_idle i=%0d got=%b%b%b exp=000", i, busy, done, reg_write_en);
      end
      commit_writes();
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_busy;
    logic [6:0] exp_done;
    int         c0;
    exp_busy = 7'b0011011;
    exp_done = 7'b0100100;
    mem[16'h0050] = 16'h7777;
    regs[0] = 16'h0000;
    is_lm = 1'b1; base_addr = 16'h0050; reg_mask = 8'h01; start = 1'b1;
    c0 = cyc;
    push_expect(1'b1, 16'h0050, 8'h01, c0);
    push_expect(1'b1, 16'h0050, 8'h01, c0 + 3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks += 2;
      if (busy !== exp_busy[i]) begin errors++; $display("FAIL b2b_busy i=%0d got=%b exp=%b", i, busy, exp_busy[i]); end
      if (done !== exp_done[i]) begin errors++; $display("FAIL b2b_done i=%0d got=%b exp=%b", i, done, exp_done[i]); end
      commit_writes();
      next_cycle();
      if (i == 4) start = 1'b0;
    end
    checks += 2;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_missing got=%0d exp=0", sb.size());
      sb.delete();
    end
    if (regs[0] !== 16'h7777) begin errors++; $display("FAIL b2b_r0 got=%h exp=7777", regs[0]); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int k = 0; k < 8; k++) regs[k] = 16'hE000 + 16'(k);
    test_reset();
    test_lm_basic();
    test_sm_basic();
    test_empty_mask();
    test_wrap();
    test_reset_mid_xfer();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle sequencer for the load-multiple (LM) and store-multiple (SM) instructions. It sits between the decoder, the register file and data memory. On a start request it walks an 8-bit register mask from R0 to R7. For every set bit it issues one register-file write (LM) or one memory write (SM) per cycle, at consecutive memory addresses from a base. While it runs it asserts `busy`, which the core uses to hold the PC and stall fetch.

## Interface
- `DATA_WIDTH`, default 16: register and memory word width.
- `ADDR_STEP`, default 1: address increment per transferred register, in words.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: decoder request; sampled only in IDLE.
- `is_lm` in 1: 1 = LM (memory to registers), 0 = SM (registers to memory); latched on accept.
- `base_addr` in 16: first memory address (contents of RA); latched on accept.
- `reg_mask` in 8: bit i selects Ri; latched on accept.
- `reg_read_addr` out 3: register-file read address (SM source register).
- `reg_read_data` in 16: register-file read data for `reg_read_addr`.
- `reg_write_en` out 1: register-file write enable (LM only).
- `reg_write_dest` out 3: register-file write destination.
- `reg_write_data` out 16: register-file write data, equal to `mem_rd_data`.
- `mem_addr` out 16: data-memory address.
- `mem_rd_data` in 16: data-memory combinational read data.
- `mem_wr_en` out 1: data-memory write enable (SM only).
- `mem_wr_data` out 16: data-memory write data, equal to `reg_read_data`.
- `busy` out 1: the core must hold the PC while this is high.
- `done` out 1: single-cycle completion pulse.

## Operation
- Internal state:
  - FSM states IDLE, XFER, DONE.
  - `rem_mask`[7:0], `cur_addr`[15:0], `op_lm`.
- IDLE:
  - Outputs `reg_write_en`, `mem_wr_en` and `done` are 0.
  - On `start`=1, latch `rem_mask`←`reg_mask`, `cur_addr`←`base_addr` and `op_lm`←`is_lm`.
  - Next state is XFER if `reg_mask`≠0, otherwise DONE.
- XFER:
  - Index `idx` = lowest set bit of `rem_mask` (priority R0 first).
  - `mem_addr`=`cur_addr`.
  - LM: `reg_write_en`=1, `reg_write_dest`=`idx`, `reg_write_data`=`mem_rd_data`.
  - SM: `reg_read_addr`=`idx`, `mem_wr_en`=1, `mem_wr_data`=`reg_read_data`.
  - At the clock edge, clear bit `idx` of `rem_mask` and set `cur_addr`←`cur_addr`+`ADDR_STEP` (mod 2^16).
  - Go to DONE when the updated `rem_mask` is 0.
- DONE:
  - `done`=1 and `busy`=0; no transfer is issued.
  - `start` is ignored, because the same LM/SM instruction is still at the PC this cycle.
  - Next state is IDLE.
- `busy` is combinational: `busy` = (IDLE & `start`) | XFER.
  - In the accept cycle this holds the PC.
  - In DONE the PC is free to advance.
- Latched operands are not affected by changes on `is_lm`, `base_addr` or `reg_mask` after accept.
- A mask bit 7 set on LM writes R7; the register file gives an explicit R7 write priority over `pc_en`, so the sequencer has no special case.
- Idle output values: `mem_addr`=`cur_addr`, `reg_read_addr`=0, `reg_write_dest`=0.

## Timing
- Reset, asynchronous and immediate:
  - State IDLE, `rem_mask`=0, `cur_addr`=0, `op_lm`=0.
  - `reg_write_en`=0, `mem_wr_en`=0, `done`=0.
  - `busy`=0 unless `start` is high.
  - A reset mid-XFER aborts the operation; transfers already committed stay, and no further write occurs.
- Latency for N = popcount(`reg_mask`):
  - Accept at cycle 0, transfers in cycles 1..N, `done` in cycle N+1, IDLE in cycle N+2.
  - N=0: `done` in cycle 1.
- Memory read is combinational and memory write is synchronous, so each transfer completes in exactly one cycle; there are no wait states.
- Address wrap: `cur_addr` 0xFFFF + 1 → 0x0000; no error is flagged.
- Maximum N=8, which gives 10 cycles from accept to return to IDLE.

## Test plan
- LM, `reg_mask`=0x16, `base_addr`=0x0040, memory 0x40..0x42 = 0xAAAA/0xBBBB/0xCCCC:
  - R1=0xAAAA in cycle 1, R2=0xBBBB in cycle 2, R4=0xCCCC in cycle 3.
  - `done` in cycle 4; `busy` high in cycles 0-3.
- SM, `reg_mask`=0x81, `base_addr`=0x0100, R0=0x1234, R7=0x5678:
  - mem[0x0100]=0x1234 and mem[0x0101]=0x5678.
  - No register write occurs; `done` in cycle 3.
- `reg_mask`=0x00 with `start`:
  - No write of either kind.
  - `busy`=1 in cycle 0 only, `done`=1 in cycle 1.
- SM, `base_addr`=0xFFFF, `reg_mask`=0x03:
  - Addresses 0xFFFF then 0x0000, holding R0 and R1 respectively.
- LM, `reg_mask`=0xFF:
  - Assert `rst` during cycle 3: outputs go to zero immediately.
  - Only R0 and R1 are written; after release the block sits in IDLE.
- `start` held high continuously with `reg_mask`=0x01:
  - `start` is ignored in DONE (cycle 2).
  - A new accept occurs in cycle 3, giving a second transfer in cycle 4.
